// File: rtl/sys_cmd_ctrl.sv
// Command controller that decodes UART command frames, sequences RF reads and writes
// and ALU operations, and returns results to the UART transmitter as byte frames.
module sys_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]   RF_ADDR,
   output logic                    RF_WR_EN,
   output logic                    RF_RD_EN,
   output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
   input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
   input  logic                    RF_RD_VLD,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    TX_FULL
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LSB, TX_MSB
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [2*DATA_WIDTH-1:0] result_q, result_d;
   logic                    alu_op_q, alu_op_d;
   logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
   logic                    rf_wr_en_q, rf_wr_en_d;
   logic                    rf_rd_en_q, rf_rd_en_d;
   logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
   logic                    alu_en_q, alu_en_d;
   logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
   logic                    clk_gate_en_q, clk_gate_en_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_vld_q, tx_vld_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         result_q      <= '0;
         alu_op_q      <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         rf_wr_data_q  <= '0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         tx_data_q     <= '0;
         tx_vld_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         result_q      <= result_d;
         alu_op_q      <= alu_op_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         rf_wr_data_q  <= rf_wr_data_d;
         alu_en_q      <= alu_en_d;
         alu_fun_q     <= alu_fun_d;
         clk_gate_en_q <= clk_gate_en_d;
         tx_data_q     <= tx_data_d;
         tx_vld_q      <= tx_vld_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      result_d     = result_q;
      alu_op_d     = alu_op_q;
      rf_addr_d    = rf_addr_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rf_wr_data_d = rf_wr_data_q;
      alu_en_d     = 1'b0;
      alu_fun_d    = alu_fun_q;
      tx_data_d    = tx_data_q;
      tx_vld_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_WR)          state_d = WR_ADDR;
               else if (RX_P_DATA == CMD_RD)     state_d = RD_ADDR;
               else if (RX_P_DATA == CMD_ALU_OP) state_d = OPA;
               else if (RX_P_DATA == CMD_ALU_NO) state_d = FUN;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               rf_addr_d    = addr_q;
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d     = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_rd_en_d = 1'b1;
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (RF_RD_VLD) begin
               result_d = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
               alu_op_d = 1'b0;
               state_d  = TX_LSB;
            end
         end
         OPA: begin
            if (RX_D_VLD) begin
               rf_addr_d    = '0;
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = OPB;
            end
         end
         OPB: begin
            if (RX_D_VLD) begin
               rf_addr_d    = ADDR_WIDTH'(1);
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = FUN;
            end
         end
         FUN: begin
            if (RX_D_VLD) begin
               alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
               alu_en_d  = 1'b1;
               state_d   = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               result_d = ALU_OUT;
               alu_op_d = 1'b1;
               state_d  = TX_LSB;
            end
         end
         TX_LSB: begin
            if (!TX_FULL) begin
               tx_data_d = result_q[DATA_WIDTH-1:0];
               tx_vld_d  = 1'b1;
               state_d   = alu_op_q ? TX_MSB : IDLE;
            end
         end
         TX_MSB: begin
            // Skip the cycle right after the low-byte push so TX_FULL can reflect it.
            if (!TX_FULL && !tx_vld_q) begin
               tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
               tx_vld_d  = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      clk_gate_en_d = (state_d == FUN) || (state_d == ALU_WAIT);
   end

   assign RF_ADDR     = rf_addr_q;
   assign RF_WR_EN    = rf_wr_en_q;
   assign RF_RD_EN    = rf_rd_en_q;
   assign RF_WR_DATA  = rf_wr_data_q;
   assign ALU_EN      = alu_en_q;
   assign ALU_FUN     = alu_fun_q;
   assign CLK_GATE_EN = clk_gate_en_q;
   assign TX_P_DATA   = tx_data_q;
   assign TX_D_VLD    = tx_vld_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl with simple RF and ALU response models.
module tb_sys_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [3:0]  RF_ADDR;
   logic        RF_WR_EN;
   logic        RF_RD_EN;
   logic [7:0]  RF_WR_DATA;
   logic [7:0]  RF_RD_DATA;
   logic        RF_RD_VLD;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_FULL;

   sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
      .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .TX_FULL(TX_FULL)
   );

   always #5 CLK = ~CLK;

   int err_cnt = 0;
   int chk_cnt = 0;
   int wr_cnt  = 0;
   int rd_cnt  = 0;
   int alu_cnt = 0;
   int tx_cnt  = 0;

   logic [7:0]  mem [16];
   logic [11:0] wr_q [$];
   logic [7:0]  tx_q [$];
   logic [3:0]  fun_q [$];
   logic [3:0]  exp_rd_addr;
   logic [11:0] wr_e;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
      repeat (3) @(posedge CLK);
      $display("rx byte 0x%02h", b);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && (tx_q.size() != 0 || wr_q.size() != 0 || fun_q.size() != 0); i++)
         @(posedge CLK);
      repeat (4) @(posedge CLK);
      check_val("drain_tx", tx_q.size(), 0);
      check_val("drain_wr", wr_q.size(), 0);
      check_val("drain_fun", fun_q.size(), 0);
   endtask

   // Output monitor / scoreboard, sampled away from the active edge.
   always @(negedge CLK) begin
      if (RST) begin
         if (RF_WR_EN) begin
            wr_cnt++;
            mem[RF_ADDR] = RF_WR_DATA;
            $display("rf write addr=0x%0h data=0x%02h", RF_ADDR, RF_WR_DATA);
            if (wr_q.size() == 0) check_val("wr_unexpected", 1, 0);
            else begin
               wr_e = wr_q.pop_front();
               check_val("wr_addr", {28'd0, RF_ADDR}, {28'd0, wr_e[11:8]});
               check_val("wr_data", {24'd0, RF_WR_DATA}, {24'd0, wr_e[7:0]});
            end
         end
         if (RF_RD_EN) begin
            rd_cnt++;
            $display("rf read addr=0x%0h", RF_ADDR);
            check_val("rd_addr", {28'd0, RF_ADDR}, {28'd0, exp_rd_addr});
         end
         if (ALU_EN) begin
            alu_cnt++;
            $display("alu start fun=0x%0h", ALU_FUN);
            check_val("gate_at_alu_en", {31'd0, CLK_GATE_EN}, 1);
            if (fun_q.size() == 0) check_val("alu_unexpected", 1, 0);
            else check_val("alu_fun", {28'd0, ALU_FUN}, {28'd0, fun_q.pop_front()});
         end
         if (ALU_OUT_VLD) check_val("gate_at_alu_vld", {31'd0, CLK_GATE_EN}, 1);
         if (TX_D_VLD) begin
            tx_cnt++;
            $display("tx byte 0x%02h", TX_P_DATA);
            check_val("tx_while_full", {31'd0, TX_FULL}, 0);
            check_val("gate_at_tx", {31'd0, CLK_GATE_EN}, 0);
            if (tx_q.size() == 0) check_val("tx_unexpected", 1, 0);
            else check_val("tx_byte", {24'd0, TX_P_DATA}, {24'd0, tx_q.pop_front()});
         end
      end
   end

   // RF read model: data returned two cycles after the read strobe.
   initial begin
      logic [3:0] a;
      RF_RD_VLD  = 1'b0;
      RF_RD_DATA = '0;
      forever begin
         @(negedge CLK);
         if (RST && RF_RD_EN) begin
            a = RF_ADDR;
            repeat (2) @(posedge CLK);
            #1;
            RF_RD_DATA = mem[a];
            RF_RD_VLD  = 1'b1;
            @(posedge CLK); #1;
            RF_RD_VLD  = 1'b0;
         end
      end
   end

   // ALU model: add / sub / mul, result three cycles after ALU_EN.
   initial begin
      logic [7:0]  op_a, op_b;
      logic [3:0]  f;
      logic [15:0] r;
      ALU_OUT_VLD = 1'b0;
      ALU_OUT     = '0;
      forever begin
         @(negedge CLK);
         if (RST && ALU_EN) begin
            op_a = mem[0];
            op_b = mem[1];
            f    = ALU_FUN;
            case (f)
               4'd0:    r = {8'd0, op_a} + {8'd0, op_b};
               4'd1:    r = {8'd0, op_a} - {8'd0, op_b};
               4'd2:    r = {8'd0, op_a} * {8'd0, op_b};
               default: r = 16'd0;
            endcase
            repeat (3) @(posedge CLK);
            #1;
            ALU_OUT     = r;
            ALU_OUT_VLD = 1'b1;
            @(posedge CLK); #1;
            ALU_OUT_VLD = 1'b0;
         end
      end
   end

   initial begin
      int s_wr, s_rd, s_alu, s_tx;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      RST = 1'b0;
      RX_P_DATA = '0;
      RX_D_VLD = 1'b0;
      TX_FULL = 1'b0;
      exp_rd_addr = '0;
      repeat (3) @(negedge CLK);
      check_val("reset_outputs", {3'd0, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN,
                                  ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
      @(posedge CLK); #1;
      RST = 1'b1;
      repeat (2) @(posedge CLK);

      // RF write
      s_wr = wr_cnt; s_tx = tx_cnt;
      wr_q.push_back({4'hA, 8'h0F});
      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h0F);
      wait_drain(100);
      check_val("wr_once", wr_cnt - s_wr, 1);
      check_val("wr_no_tx", tx_cnt - s_tx, 0);

      // RF read
      s_rd = rd_cnt; s_tx = tx_cnt;
      exp_rd_addr = 4'hA;
      tx_q.push_back(8'h0F);
      send_byte(8'hBB); send_byte(8'h0A);
      wait_drain(100);
      check_val("rd_once", rd_cnt - s_rd, 1);
      check_val("rd_one_tx", tx_cnt - s_tx, 1);

      // ALU with operands (add)
      s_wr = wr_cnt; s_alu = alu_cnt; s_tx = tx_cnt;
      wr_q.push_back({4'h0, 8'h05});
      wr_q.push_back({4'h1, 8'h03});
      fun_q.push_back(4'h0);
      tx_q.push_back(8'h08);
      tx_q.push_back(8'h00);
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
      wait_drain(100);
      check_val("aluop_wr", wr_cnt - s_wr, 2);
      check_val("aluop_en", alu_cnt - s_alu, 1);
      check_val("aluop_tx", tx_cnt - s_tx, 2);
      check_val("gate_idle", {31'd0, CLK_GATE_EN}, 0);

      // ALU without operands (multiply) with TX_FULL stall
      wr_q.push_back({4'h0, 8'h06});
      send_byte(8'hAA); send_byte(8'h00); send_byte(8'h06);
      wr_q.push_back({4'h1, 8'h07});
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h07);
      wait_drain(100);
      TX_FULL = 1'b1;
      s_tx = tx_cnt;
      fun_q.push_back(4'h2);
      tx_q.push_back(8'h2A);
      tx_q.push_back(8'h00);
      send_byte(8'hDD); send_byte(8'h02);
      repeat (20) @(posedge CLK);
      check_val("stall_no_push", tx_cnt - s_tx, 0);
      #1 TX_FULL = 1'b0;
      wait_drain(100);
      check_val("mul_tx", tx_cnt - s_tx, 2);

      // Non-command byte ignored, then write RF[1]
      s_wr = wr_cnt; s_tx = tx_cnt;
      wr_q.push_back({4'h1, 8'h33});
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h33);
      wait_drain(100);
      check_val("junk_then_wr", wr_cnt - s_wr, 1);
      check_val("junk_no_tx", tx_cnt - s_tx, 0);

      // Reset mid-frame abandons it
      s_wr = wr_cnt;
      send_byte(8'hAA); send_byte(8'h02);
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      check_val("async_reset_outputs", {3'd0, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN,
                                        ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      send_byte(8'h44);
      repeat (5) @(posedge CLK);
      check_val("abandoned_frame", wr_cnt - s_wr, 0);
      wr_q.push_back({4'h2, 8'h44});
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h44);
      wait_drain(100);
      check_val("post_reset_wr", wr_cnt - s_wr, 1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
